adc_avg_decim: RTL and testbench
================================

// Module: adc_avg_decim
// PURPOSE
//  Downstream stage of the serial ADC receiver. Takes each 11-bit parallel sample
//  qualified by the receiver's rx_done_tick and accumulates a window of 2**LOG2N
//  samples. Emits the window's truncated mean plus its min/max on a valid/ready port.
//  Runs on the receiver's sclk, so rx_done_tick arrives as a 1-cycle pulse and no CDC is needed.
// PARAMETERS
//  DW     11  sample width, matching the receiver's dout
//  LOG2N  3   log2 of window length (N = 8); legal range 1..6
// PORTS
//  sclk         in   1         clock; all logic on posedge
//  rst          in   1         reset, synchronous, active-high
//  en           in   1         1 = accept samples; 0 = ignore ticks, partial window held
//  restart      in   1         1-cycle pulse: discard partial window (count/sum/min/max)
//  sample_tick  in   1         connect to rx_done_tick; sample_in valid when high
//  sample_in    in   DW        connect to receiver dout
//  avg_ready    in   1         consumer ready
//  avg_valid    out  1         result available; held until accepted
//  avg_out      out  DW        floor(sum of N samples / N)
//  min_out      out  DW        minimum sample of the window
//  max_out      out  DW        maximum sample of the window
//  overrun      out  1         sticky: a completed window was dropped
//  clr_overrun  in   1         clears overrun on next posedge
// BEHAVIOUR
//  - Reset (sync, rst=1 at posedge): avg_valid=0, avg_out=0, min_out=0, max_out=0, overrun=0;
//    cnt=0, sum=0, win_min=all-ones, win_max=0. Reset mid-window discards everything.
//  - Accept = sample_tick & en & ~restart at posedge; ticks with en=0 are lost, not queued.
//  - Accumulator sum is DW+LOG2N bits, unsigned, and cannot overflow.
//  - Window counter cnt is LOG2N bits and wraps N-1 -> 0.
//  - Each accept: sum+=sample_in; win_min/win_max updated (unsigned compare); cnt+=1.
//  - Final accept (cnt==N-1): result = (sum+sample_in)>>LOG2N, truncation only.
//    min/max for the result include that final sample.
//    sum/min/max re-initialise on the same edge, so the next tick starts a fresh window.
//  - Latency: avg_valid and the result regs update at the posedge of the final accept,
//    i.e. visible the cycle after the tick.
//  - Output FSM, two states:
//    EMPTY: avg_valid=0; window done -> load result, go FULL.
//    FULL:  avg_valid=1; outputs stable.
//           avg_ready=1 with no completion -> EMPTY.
//           avg_ready=1 with completion on the same edge -> load new result, stay FULL
//           (valid never drops).
//           avg_ready=0 with completion -> new result dropped, outputs unchanged, overrun<=1.
//  - overrun: set has priority over clr_overrun on the same edge. Cleared only by rst or clr_overrun.
//  - restart: clears cnt/sum/min/max; does not touch avg_valid/outputs/overrun.
//    restart with sample_tick on the same edge: sample discarded.
//  - Outputs change only on posedge and only when loading a result; no combinational in->out paths.
// TESTING
//  1 LOG2N=2; samples 100,200,300,400, ready=1 -> avg_valid 1 cycle, avg=250, min=100, max=400.
//  2 LOG2N=2; samples 1,1,1,2 -> avg=1 (truncation); 4x 2047 -> avg=2047, no overflow.
//  3 Hold ready=0 across two windows -> first result kept, second dropped, overrun=1.
//    Then clr_overrun -> overrun=0.
//  4 Pulse ready on the same edge as next window's final tick -> avg_valid stays 1, new values shown.
//  5 Two samples, then en=0 with 3 ticks, then en=1 with 2 samples 8,8 (first 4,4)
//    -> avg=6, min=4, max=8.
//  6 rst or restart after 3 samples, then 4 samples of 10 -> avg=10, min=10, max=10.
//    rst also clears avg_valid.

Source files
------------

// File: rtl/adc_avg_decim.sv
// Window averager/decimator behind the serial ADC receiver: accumulates 2**LOG2N
// samples and presents their truncated mean, min and max on a valid/ready port.
module adc_avg_decim #(
    parameter int DW    = 11,
    parameter int LOG2N = 3
) (
    input  logic          sclk,
    input  logic          rst,
    input  logic          en,
    input  logic          restart,
    input  logic          sample_tick,
    input  logic [DW-1:0] sample_in,
    input  logic          avg_ready,
    output logic          avg_valid,
    output logic [DW-1:0] avg_out,
    output logic [DW-1:0] min_out,
    output logic [DW-1:0] max_out,
    output logic          overrun,
    input  logic          clr_overrun
);

    localparam int SW = DW + LOG2N;

    typedef enum logic {EMPTY, FULL} state_t;

    state_t           state;
    logic [LOG2N-1:0] cnt;
    logic [SW-1:0]    sum;
    logic [DW-1:0]    win_min;
    logic [DW-1:0]    win_max;

    logic             accept;
    logic             win_done;
    logic [SW-1:0]    sum_nxt;
    logic [DW-1:0]    min_nxt;
    logic [DW-1:0]    max_nxt;

    // Mean of the window: plain right shift, no rounding term.
    function automatic logic [DW-1:0] mean_trunc(input logic [SW-1:0] s);
        logic [SW-1:0] q;
        q = s >> LOG2N;
        return q[DW-1:0];
    endfunction

    assign accept   = sample_tick & en & ~restart;
    assign win_done = accept & (cnt == {LOG2N{1'b1}});
    assign sum_nxt  = sum + SW'(sample_in);
    assign min_nxt  = (sample_in < win_min) ? sample_in : win_min;
    assign max_nxt  = (sample_in > win_max) ? sample_in : win_max;

    // Window accumulation; the final accept re-arms the window on the same edge.
    always_ff @(posedge sclk) begin
        if (rst || restart) begin
            cnt     <= '0;
            sum     <= '0;
            win_min <= '1;
            win_max <= '0;
        end else if (accept) begin
            cnt <= cnt + 1'b1;
            if (win_done) begin
                sum     <= '0;
                win_min <= '1;
                win_max <= '0;
            end else begin
                sum     <= sum_nxt;
                win_min <= min_nxt;
                win_max <= max_nxt;
            end
        end
    end

    // Output FSM with registered result; clr_overrun is overridden by a drop on the same edge.
    always_ff @(posedge sclk) begin
        if (rst) begin
            state     <= EMPTY;
            avg_valid <= 1'b0;
            avg_out   <= '0;
            min_out   <= '0;
            max_out   <= '0;
            overrun   <= 1'b0;
        end else begin
            if (clr_overrun)
                overrun <= 1'b0;
            case (state)
                EMPTY: begin
                    if (win_done) begin
                        avg_out   <= mean_trunc(sum_nxt);
                        min_out   <= min_nxt;
                        max_out   <= max_nxt;
                        avg_valid <= 1'b1;
                        state     <= FULL;
                    end
                end
                FULL: begin
                    if (win_done && avg_ready) begin
                        avg_out <= mean_trunc(sum_nxt);
                        min_out <= min_nxt;
                        max_out <= max_nxt;
                    end else if (win_done) begin
                        overrun <= 1'b1;
                    end else if (avg_ready) begin
                        avg_valid <= 1'b0;
                        state     <= EMPTY;
                    end
                end
                default: begin
                    avg_valid <= 1'b0;
                    state     <= EMPTY;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adc_avg_decim.sv
// Table-driven bench for adc_avg_decim with N=4: each row is one clock of inputs
// and the outputs expected just after that clock edge.
module tb_adc_avg_decim;

    localparam int DW    = 11;
    localparam int LOG2N = 2;

    logic          sclk = 1'b0;
    logic          rst;
    logic          en;
    logic          restart;
    logic          sample_tick;
    logic [DW-1:0] sample_in;
    logic          avg_ready;
    logic          avg_valid;
    logic [DW-1:0] avg_out;
    logic [DW-1:0] min_out;
    logic [DW-1:0] max_out;
    logic          overrun;
    logic          clr_overrun;

    int n_vec  = 0;
    int n_fail = 0;

    typedef struct {
        logic          rst;
        logic          tick;
        logic          en;
        logic          rs;
        logic          rdy;
        logic          clr;
        logic [DW-1:0] smp;
        logic          v;
        logic [DW-1:0] avg;
        logic [DW-1:0] mn;
        logic [DW-1:0] mx;
        logic          ovr;
    } vec_t;

    vec_t vq[$];

    always #5 sclk = ~sclk;

    adc_avg_decim #(.DW(DW), .LOG2N(LOG2N)) dut (
        .sclk        (sclk),
        .rst         (rst),
        .en          (en),
        .restart     (restart),
        .sample_tick (sample_tick),
        .sample_in   (sample_in),
        .avg_ready   (avg_ready),
        .avg_valid   (avg_valid),
        .avg_out     (avg_out),
        .min_out     (min_out),
        .max_out     (max_out),
        .overrun     (overrun),
        .clr_overrun (clr_overrun)
    );

    task automatic add(input logic r, input logic tk, input logic e, input logic rs,
                       input logic rdy, input logic clr, input int smp,
                       input logic v, input int avg, input int mn, input int mx,
                       input logic ovr);
        vec_t x;
        x.rst = r; x.tick = tk; x.en = e; x.rs = rs; x.rdy = rdy; x.clr = clr;
        x.smp = DW'(smp); x.v = v; x.avg = DW'(avg); x.mn = DW'(mn); x.mx = DW'(mx);
        x.ovr = ovr;
        vq.push_back(x);
    endtask

    // Drive one row, clock it in, and compare the outputs 1 ns after the edge.
    task automatic apply(input vec_t x, input string name);
        rst = x.rst; sample_tick = x.tick; en = x.en; restart = x.rs;
        avg_ready = x.rdy; clr_overrun = x.clr; sample_in = x.smp;
        @(posedge sclk);
        #1;
        n_vec++;
        if ({avg_valid, avg_out, min_out, max_out, overrun} !==
            {x.v, x.avg, x.mn, x.mx, x.ovr}) begin
            n_fail++;
            $display("FAIL %s: got v=%0b avg=%0d min=%0d max=%0d ovr=%0b, want v=%0b avg=%0d min=%0d max=%0d ovr=%0b",
                     name, avg_valid, avg_out, min_out, max_out, overrun,
                     x.v, x.avg, x.mn, x.mx, x.ovr);
        end
    endtask

    initial begin
        vec_t h;
        rst = 1'b1; en = 1'b1; restart = 1'b0; sample_tick = 1'b0;
        sample_in = '0; avg_ready = 1'b0; clr_overrun = 1'b0;
        @(posedge sclk);

        // Reset state
        h = '{1,0,1,0,0,0,0, 0,0,0,0,0};
        apply(h, "reset");

        // 1: basic window, ready high
        add(0,1,1,0,1,0,100, 0,0,0,0,0);
        add(0,1,1,0,1,0,200, 0,0,0,0,0);
        add(0,1,1,0,1,0,300, 0,0,0,0,0);
        add(0,1,1,0,1,0,400, 1,250,100,400,0);
        add(0,0,1,0,1,0,0,   0,250,100,400,0);
        // 2: truncation, then full-scale without overflow
        add(0,1,1,0,1,0,1,   0,250,100,400,0);
        add(0,1,1,0,1,0,1,   0,250,100,400,0);
        add(0,1,1,0,1,0,1,   0,250,100,400,0);
        add(0,1,1,0,1,0,2,   1,1,1,2,0);
        add(0,0,1,0,1,0,0,   0,1,1,2,0);
        add(0,1,1,0,1,0,2047, 0,1,1,2,0);
        add(0,1,1,0,1,0,2047, 0,1,1,2,0);
        add(0,1,1,0,1,0,2047, 0,1,1,2,0);
        add(0,1,1,0,1,0,2047, 1,2047,2047,2047,0);
        add(0,0,1,0,1,0,0,    0,2047,2047,2047,0);
        // 3: ready low across windows -> drop + overrun; clear; set beats clear
        add(0,1,1,0,0,0,4,   0,2047,2047,2047,0);
        add(0,1,1,0,0,0,8,   0,2047,2047,2047,0);
        add(0,1,1,0,0,0,12,  0,2047,2047,2047,0);
        add(0,1,1,0,0,0,16,  1,10,4,16,0);
        add(0,1,1,0,0,0,1,   1,10,4,16,0);
        add(0,1,1,0,0,0,1,   1,10,4,16,0);
        add(0,1,1,0,0,0,1,   1,10,4,16,0);
        add(0,1,1,0,0,0,1,   1,10,4,16,1);
        add(0,0,1,0,0,1,0,   1,10,4,16,0);
        add(0,1,1,0,0,0,5,   1,10,4,16,0);
        add(0,1,1,0,0,0,5,   1,10,4,16,0);
        add(0,1,1,0,0,0,5,   1,10,4,16,0);
        add(0,1,1,0,0,1,5,   1,10,4,16,1);
        add(0,0,1,0,0,1,0,   1,10,4,16,0);
        // 4: ready pulsed on the final tick -> valid stays, new result loaded
        add(0,1,1,0,0,0,20,  1,10,4,16,0);
        add(0,1,1,0,0,0,20,  1,10,4,16,0);
        add(0,1,1,0,0,0,20,  1,10,4,16,0);
        add(0,1,1,0,1,0,40,  1,25,20,40,0);
        add(0,0,1,0,0,0,0,   1,25,20,40,0);
        add(0,0,1,0,1,0,0,   0,25,20,40,0);
        // 5: ticks with en low are lost
        add(0,1,1,0,1,0,4,   0,25,20,40,0);
        add(0,1,1,0,1,0,4,   0,25,20,40,0);
        add(0,1,0,0,1,0,100, 0,25,20,40,0);
        add(0,1,0,0,1,0,100, 0,25,20,40,0);
        add(0,1,0,0,1,0,100, 0,25,20,40,0);
        add(0,1,1,0,1,0,8,   0,25,20,40,0);
        add(0,1,1,0,1,0,8,   1,6,4,8,0);
        add(0,0,1,0,1,0,0,   0,6,4,8,0);
        // 6: restart mid-window, with a coincident tick that must be discarded
        add(0,1,1,0,1,0,50,  0,6,4,8,0);
        add(0,1,1,0,1,0,50,  0,6,4,8,0);
        add(0,1,1,0,1,0,50,  0,6,4,8,0);
        add(0,1,1,1,1,0,0,   0,6,4,8,0);
        add(0,1,1,0,1,0,10,  0,6,4,8,0);
        add(0,1,1,0,1,0,10,  0,6,4,8,0);
        add(0,1,1,0,1,0,10,  0,6,4,8,0);
        add(0,1,1,0,1,0,10,  1,10,10,10,0);
        add(0,0,1,0,1,0,0,   0,10,10,10,0);

        foreach (vq[i]) apply(vq[i], $sformatf("row%0d", i));

        // rst mid-window with a pending result: clears valid/outputs and partial window
        for (int i = 0; i < 4; i++) begin
            h = '{0,1,1,0,0,0,3, 0,10,10,10,0};
            if (i == 3) begin h.v = 1; h.avg = 3; h.mn = 3; h.mx = 3; end
            apply(h, $sformatf("pre_rst%0d", i));
        end
        for (int i = 0; i < 3; i++) begin
            h = '{0,1,1,0,0,0,99, 1,3,3,3,0};
            apply(h, $sformatf("partial%0d", i));
        end
        h = '{1,0,1,0,0,0,0, 0,0,0,0,0};
        apply(h, "mid_rst");
        for (int i = 0; i < 4; i++) begin
            h = '{0,1,1,0,1,0,10, 0,0,0,0,0};
            if (i == 3) begin h.v = 1; h.avg = 10; h.mn = 10; h.mx = 10; end
            apply(h, $sformatf("post_rst%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
